// File: rtl/instr_fetch.sv
// Instruction-fetch stage: req/ack read of instruction memory into an instruction
// register, with R/I-type field decode and a sign-extended immediate for the PC stage.
module instr_fetch #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [31:0]       imm_ext,
    output logic              instr_valid,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    // The wait counter starts at 0 on the start edge; the edge on which it would
    // step to TIMEOUT-1 without an ack is the abort edge.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (fetch_start) begin
                    addr_d  = pc;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Substitute sll $0,$0,0 so the datapath can still advance.
                    instr_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign busy        = (state_q == REQ);
    assign instr_valid = (state_q == DONE) || (state_q == ERR);
    assign imem_addr   = addr_q;
    assign fetch_err   = err_q;
    assign instr       = instr_q;

    assign opcode  = instr_q[31:26];
    assign rs      = instr_q[25:21];
    assign rt      = instr_q[20:16];
    assign rd      = instr_q[15:11];
    assign shamt   = instr_q[10:6];
    assign funct   = instr_q[5:0];
    assign imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: decode vector table, hand-written multi-cycle sequences,
// and a randomized run against a transaction-level reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_start;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    // Instance A: default TIMEOUT=16
    logic        req_a, vld_a, busy_a, err_a;
    logic [31:0] addr_a, instr_a, imm_a;
    logic [5:0]  op_a, fn_a;
    logic [4:0]  rs_a, rt_a, rd_a, sh_a;
    // Instance B: TIMEOUT=4
    logic        req_b, vld_b, busy_b, err_b;
    logic [31:0] addr_b, instr_b, imm_b;
    logic [5:0]  op_b, fn_b;
    logic [4:0]  rs_b, rt_b, rd_b, sh_b;

    instr_fetch #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_start(fetch_start),
        .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr_a), .opcode(op_a), .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(sh_a),
        .funct(fn_a), .imm_ext(imm_a), .instr_valid(vld_a), .busy(busy_a), .fetch_err(err_a)
    );

    instr_fetch #(.ADDR_W(32), .TIMEOUT(4)) dut_t4 (
        .clk(clk), .reset(reset), .pc(pc), .fetch_start(fetch_start),
        .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr_b), .opcode(op_b), .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(sh_b),
        .funct(fn_b), .imm_ext(imm_b), .instr_valid(vld_b), .busy(busy_b), .fetch_err(err_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [31:0] imm;
    } vec_t;

    // Reference model: one outstanding-fetch record per instance.
    int          m_to[2];
    logic        m_out[2];
    int          m_age[2];
    logic [31:0] m_instr[2];
    logic [31:0] m_addr[2];
    logic        m_err[2];
    logic        m_vld[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_age[k] = 0; m_instr[k] = 0;
            m_addr[k] = 0; m_err[k] = 0; m_vld[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 1'b0;
            if (m_out[k]) begin
                if (imem_ack) begin
                    m_instr[k] = imem_rdata; m_out[k] = 0; m_vld[k] = 1;
                end else begin
                    m_age[k]++;
                    if (m_age[k] == m_to[k] - 1) begin
                        m_instr[k] = 0; m_err[k] = 1; m_out[k] = 0; m_vld[k] = 1;
                    end
                end
            end else if (fetch_start) begin
                m_addr[k] = pc; m_err[k] = 0; m_out[k] = 1; m_age[k] = 0;
            end
        end
    endtask

    task automatic cmp_inst(input int k, input logic [31:0] ins, input logic [31:0] adr,
                            input logic vld, input logic bsy, input logic rq,
                            input logic er, input logic [31:0] imm);
        logic [31:0] exp_imm;
        exp_imm = {{16{m_instr[k][15]}}, m_instr[k][15:0]};
        chk($sformatf("rnd%0d instr", k), ins, m_instr[k]);
        chk($sformatf("rnd%0d addr", k), adr, m_addr[k]);
        chk($sformatf("rnd%0d valid", k), 32'(vld), 32'(m_vld[k]));
        chk($sformatf("rnd%0d busy", k), 32'(bsy), 32'(m_out[k]));
        chk($sformatf("rnd%0d req", k), 32'(rq), 32'(m_out[k]));
        chk($sformatf("rnd%0d err", k), 32'(er), 32'(m_err[k]));
        chk($sformatf("rnd%0d imm", k), imm, exp_imm);
    endtask

    initial begin
        vec_t vt[4];
        int   bcnt;

        vt[0] = '{32'h0000_0004, 32'h8C22_0010, 6'h23, 5'd1, 5'd2,  5'd0,  5'd0,  6'h10, 32'h0000_0010};
        vt[1] = '{32'h0000_0010, 32'h1022_FFFE, 6'h04, 5'd1, 5'd2,  5'd31, 5'd31, 6'h3E, 32'hFFFF_FFFE};
        vt[2] = '{32'h0000_1234, 32'h012A_4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 32'h0000_4020};
        vt[3] = '{32'hFFFF_FFFF, 32'h0003_1080, 6'h00, 5'd0, 5'd3,  5'd2,  5'd2,  6'h00, 32'h0000_1080};
        m_to[0] = 16;
        m_to[1] = 4;

        reset = 1'b0; pc = '0; fetch_start = 1'b0; imem_rdata = '0; imem_ack = 1'b0;
        #3;
        chk("rst req",   32'(req_a),  0);
        chk("rst busy",  32'(busy_a), 0);
        chk("rst valid", 32'(vld_a),  0);
        chk("rst err",   32'(err_a),  0);
        chk("rst addr",  addr_a, 0);
        chk("rst instr", instr_a, 0);
        chk("rst imm",   imm_a, 0);
        chk("rst fields", {op_a, rs_a, rt_a, rd_a, sh_a, fn_a}, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Zero-wait fetches through the decode table
        for (int i = 0; i < 4; i++) begin
            pc = vt[i].pc; fetch_start = 1'b1;
            step();
            fetch_start = 1'b0;
            chk($sformatf("v%0d req", i),   32'(req_a), 1);
            chk($sformatf("v%0d valid0", i), 32'(vld_a), 0);
            chk($sformatf("v%0d addr", i),  addr_a, vt[i].pc);
            imem_ack = 1'b1; imem_rdata = vt[i].rdata;
            step();
            imem_ack = 1'b0; imem_rdata = 32'hA5A5_A5A5;
            chk($sformatf("v%0d valid", i), 32'(vld_a), 1);
            chk($sformatf("v%0d busy", i),  32'(busy_a), 0);
            chk($sformatf("v%0d instr", i), instr_a, vt[i].rdata);
            chk($sformatf("v%0d op", i), 32'(op_a), 32'(vt[i].op));
            chk($sformatf("v%0d rs", i), 32'(rs_a), 32'(vt[i].rs));
            chk($sformatf("v%0d rt", i), 32'(rt_a), 32'(vt[i].rt));
            chk($sformatf("v%0d rd", i), 32'(rd_a), 32'(vt[i].rd));
            chk($sformatf("v%0d sh", i), 32'(sh_a), 32'(vt[i].sh));
            chk($sformatf("v%0d fn", i), 32'(fn_a), 32'(vt[i].fn));
            chk($sformatf("v%0d imm", i), imm_a, vt[i].imm);
            step();
            chk($sformatf("v%0d pulse", i), 32'(vld_a), 0);
            chk($sformatf("v%0d hold", i), instr_a, vt[i].rdata);
        end

        // Three wait states, beq payload, starts during REQ ignored (instance A)
        bcnt = 0;
        pc = 32'h40; fetch_start = 1'b1;
        step();
        if (busy_a) bcnt++;
        for (int w = 0; w < 3; w++) begin
            pc = 32'h99; fetch_start = (w != 1);
            step();
            if (busy_a) bcnt++;
            chk("wait addr", addr_a, 32'h40);
            chk("wait valid", 32'(vld_a), 0);
        end
        fetch_start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1022_FFFE;
        step();
        imem_ack = 1'b0;
        if (busy_a) bcnt++;
        chk("wait busy cycles", bcnt, 4);
        chk("wait valid", 32'(vld_a), 1);
        chk("wait imm", imm_a, 32'hFFFF_FFFE);
        step();
        // Restore a nonzero word in instance B before the timeout check
        pc = 32'h8; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C22_0010;
        step();
        imem_ack = 1'b0;
        chk("pre-to instr", instr_b, 32'h8C22_0010);
        step();

        // Timeout on instance B (TIMEOUT=4): error after edge 3
        pc = 32'h100; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk($sformatf("to e%0d valid", e), 32'(vld_b), (e == 3) ? 1 : 0);
            chk($sformatf("to e%0d err", e),   32'(err_b), (e == 3) ? 1 : 0);
        end
        chk("to instr nop", instr_b, 0);
        chk("to busy", 32'(busy_b), 0);
        pc = 32'h104; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("to err cleared", 32'(err_b), 0);
        chk("to restart addr", addr_b, 32'h104);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        step();
        imem_ack = 1'b0;
        step();

        // Ack on the expiry edge wins
        pc = 32'h200; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step(); step();
        imem_ack = 1'b1; imem_rdata = 32'h2008_FFFF;
        step();
        imem_ack = 1'b0;
        chk("exp valid", 32'(vld_b), 1);
        chk("exp err", 32'(err_b), 0);
        chk("exp instr", instr_b, 32'h2008_FFFF);
        step();

        // Back-to-back with start held, one instruction per two cycles
        for (int i = 0; i < 6; i++) begin
            fetch_start = (i < 5); imem_ack = i[0]; pc = 32'(i / 2);
            imem_rdata = 32'h1000 + 32'(i);
            step();
            chk($sformatf("b2b%0d valid", i), 32'(vld_a), 32'(i % 2));
            chk($sformatf("b2b%0d addr", i), addr_a, 32'(i / 2));
        end
        fetch_start = 1'b0; imem_ack = 1'b0;
        step();

        // Asynchronous reset during REQ
        pc = 32'h55; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("mr req before", 32'(req_a), 1);
        #2 reset = 1'b0;
        #1;
        chk("mr req", 32'(req_a), 0);
        chk("mr busy", 32'(busy_a), 0);
        chk("mr addr", addr_a, 0);
        chk("mr instr", instr_a, 0);
        reset = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("mr late instr", instr_a, 0);
        chk("mr late valid", 32'(vld_a), 0);

        // Randomized run against the reference model
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            fetch_start = ($urandom_range(0, 2) == 0);
            imem_ack    = ($urandom_range(0, 3) == 0);
            imem_rdata  = $urandom;
            pc          = $urandom;
            @(posedge clk);
            model_step();
            #1;
            cmp_inst(0, instr_a, addr_a, vld_a, busy_a, req_a, err_a, imm_a);
            cmp_inst(1, instr_b, addr_b, vld_b, busy_b, req_b, err_b, imm_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the non-pipelined MIPS datapath, directly downstream of the PC register. It takes the current word address from the PC stage and runs a request/acknowledge read on instruction memory. It captures the returned word into an instruction register and presents the decoded R/I-type fields. It also drives the sign-extended immediate that the PC stage consumes as its branch offset.

## Interface
- `ADDR_W`, default 32: instruction address width (word address, matching the PC stage's `pc+1` stepping).
- `TIMEOUT`, default 16: maximum cycles to wait for `imem_ack` before aborting a fetch; legal range 2..255.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `pc`  in  ADDR_W  word address from the PC stage.
- `fetch_start`  in  1  single-cycle request to fetch `pc`.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  ADDR_W  registered fetch address.
- `imem_rdata`  in  32  read data; valid only in a cycle where `imem_ack`=1.
- `imem_ack`  in  1  memory completion strobe.
- `instr`  out  32  instruction register.
- `opcode`  out  6, `rs`/`rt`/`rd`/`shamt`  out  5 each, `funct`  out  6: fields of `instr`.
- `imm_ext`  out  32  sign-extended `instr[15:0]`; feeds the PC stage's `extended` input.
- `instr_valid`  out  1  one-cycle pulse when a new `instr` is captured.
- `busy`  out  1  high while a fetch is outstanding.
- `fetch_err`  out  1  sticky timeout flag; cleared by the next accepted `fetch_start`.

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - `fetch_start`=1 → latch `pc` into `imem_addr`, clear the timeout counter and `fetch_err`, go to REQ.
- REQ:
  - `imem_req`=1 and `busy`=1.
  - `imem_ack`=1 → capture `imem_rdata` into `instr`, go to DONE.
  - Otherwise increment the timeout counter.
  - Counter reaching `TIMEOUT`-1 without ack → `instr` := 0x00000000 (sll $0 nop), set `fetch_err`, go to ERR.
- DONE:
  - `instr_valid`=1 for exactly this cycle.
  - `fetch_start`=1 → behave as IDLE (back-to-back fetch, go to REQ); else go to IDLE.
- ERR:
  - `instr_valid`=1 for this cycle, so the datapath advances on the nop.
  - `fetch_start` handling is identical to DONE; otherwise go to IDLE.
- `fetch_start` while in REQ is ignored; `imem_addr` stays stable for the whole request.
- `imem_ack` outside REQ is ignored; `instr` is unchanged.
- Ack on the same edge the counter would expire: the ack wins (capture, DONE, no error).
- Decode fields are continuous slices of `instr`:
  - `opcode`=[31:26], `rs`=[25:21], `rt`=[20:16], `rd`=[15:11], `shamt`=[10:6], `funct`=[5:0].
  - `imm_ext` = {16{instr[15]}, instr[15:0]}.
- `instr` and the fields hold their last value until the next capture or nop-substitution.

## Timing
- Reset asserted (low), asynchronously:
  - state=IDLE, `imem_req`=0, `imem_addr`=0, `instr`=0, `instr_valid`=0, `busy`=0, `fetch_err`=0, counter=0.
  - All decoded outputs are therefore 0.
- Reset mid-fetch: `imem_req` drops immediately with reset, without waiting for a clock edge. A late `imem_ack` after reset release is ignored (FSM in IDLE).
- `imem_req`, `busy`, and `instr_valid` are decoded from registered state only; no combinational path from `imem_ack` or `fetch_start` to any output.
- Minimum latency, with `fetch_start` sampled at edge 0 and `imem_ack` sampled at edge 1:
  - `imem_req` high between edges 0 and 1.
  - `instr` updated at edge 1; `instr_valid` high between edges 1 and 2.
- Ack sampled at edge k gives the same pattern, shifted.
- Timeout: if no ack arrives, `instr_valid` and `fetch_err` assert after edge `TIMEOUT`-1 following the start edge.
- Back-to-back throughput: one instruction per 2 cycles with single-cycle memory.

## Test plan
- Reset: drive `reset`=0 mid-REQ → `imem_req` falls before the next edge; all outputs 0; after release, an ack on the following cycle leaves `instr`=0 and `instr_valid`=0.
- Zero-wait fetch: `pc`=0x00000004, start at edge 0, ack with `imem_rdata`=0x8C220010 at edge 1 → `imem_addr`=4, `opcode`=0x23, `rs`=1, `rt`=2, `imm_ext`=0x00000010, one `instr_valid` pulse.
- Negative immediate with wait states: ack after 3 cycles carrying 0x1022FFFE (beq) → `imm_ext`=0xFFFFFFFE, `busy` high for exactly 4 cycles, `fetch_start` pulses during REQ ignored.
- Timeout: `TIMEOUT`=4, never ack → `fetch_err`=1, `instr`=0, `instr_valid` pulse at the expected cycle; the next `fetch_start` clears `fetch_err`.
- Ack on the expiry cycle → capture succeeds, `fetch_err`=0.
- Back-to-back: `fetch_start` held in DONE with `pc` stepping 0,1,2, single-cycle acks → three `instr_valid` pulses two cycles apart, `imem_addr` 0,1,2.
